// File: rtl/tinyml_mem_pkg.sv
// Shared types and elaboration helpers for the on-chip weight/activation buffers.
package tinyml_mem_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    function automatic bit read_lat_valid(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Reset-free simple-dual-port array: byte-enabled write, registered read-before-write
// output. Kept free of resets and muxes so it maps directly onto block RAM.
module sdp_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdp_ram_buffer.sv
// Simple-dual-port buffer with clear sequencer, write-first byte-merged collision
// bypass, out-of-range masking and a 1- or 2-cycle read pipeline.
module sdp_ram_buffer
    import tinyml_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int                NB          = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
    localparam clr_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;

    generate
        if (!read_lat_valid(READ_LAT)) begin : g_bad_lat
            $fatal(1, "sdp_ram_buffer: READ_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_width
            $fatal(1, "sdp_ram_buffer: DATA_W must be a multiple of 8");
        end
    endgenerate

    clr_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLR_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLR_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            CLR_RUN: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = CLR_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy = (r_state == CLR_RUN);

    logic w_wr_acc, w_rd_acc, w_wr_in, w_rd_in, w_collide;

    assign w_wr_acc  = wr_en && !busy;
    assign w_rd_acc  = rd_en && !busy;
    assign w_wr_in   = ({1'b0, wr_addr} < DEPTH_EXT);
    assign w_rd_in   = ({1'b0, rd_addr} < DEPTH_EXT);
    assign w_collide = w_wr_acc && w_wr_in && w_rd_in && (wr_addr == rd_addr);

    // The clear sequencer owns the write port while busy.
    logic                  w_core_we;
    logic [ADDR_W-1:0]     w_core_waddr;
    logic [DATA_W-1:0]     w_core_wdata;
    logic [NB-1:0]         w_core_be;
    logic [DATA_W-1:0]     w_core_q;

    assign w_core_we    = busy || (w_wr_acc && w_wr_in);
    assign w_core_waddr = busy ? r_cnt : wr_addr;
    assign w_core_wdata = busy ? '0 : wr_data;
    assign w_core_be    = busy ? '1 : wr_be;

    sdp_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .i_wr_en   (w_core_we),
        .i_wr_addr (w_core_waddr),
        .i_wr_data (w_core_wdata),
        .i_wr_be   (w_core_be),
        .i_rd_en   (w_rd_acc && w_rd_in),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_core_q)
    );

    // r_zero1 resets high so the unreset core output is masked until the first read.
    logic                  r_v1;
    logic                  r_zero1;
    logic [NB-1:0]         r_col_be;
    logic [DATA_W-1:0]     r_col_data;
    logic [DATA_W-1:0]     w_stage1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_zero1    <= 1'b1;
            r_col_be   <= '0;
            r_col_data <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_zero1    <= !w_rd_in;
                r_col_be   <= w_collide ? wr_be : '0;
                r_col_data <= wr_data;
            end
        end
    end

    always_comb begin
        w_stage1 = '0;
        if (!r_zero1) begin
            for (int b = 0; b < NB; b++) begin
                w_stage1[8*b +: 8] = r_col_be[b] ? r_col_data[8*b +: 8] : w_core_q[8*b +: 8];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_data2;
            logic              r_v2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data2 <= '0;
                    r_v2    <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_data2 <= w_stage1;
                    end
                end
            end

            assign rd_data  = r_data2;
            assign rd_valid = r_v2;
        end else begin : g_lat1
            assign rd_data  = w_stage1;
            assign rd_valid = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_buffer.sv
// Self-checking bench: two buffers (1024 deep / 1-cycle, 1000 deep / 2-cycle) share
// one stimulus stream and are compared against a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_sdp_ram_buffer;

    localparam int DW      = 32;
    localparam int AW      = 10;
    localparam int NB      = 4;
    localparam int DEPTH_A = 1024;
    localparam int DEPTH_B = 1000;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          wrEn   = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic [NB-1:0] wrBe   = '0;
    logic          rdEn   = 1'b0;
    logic [AW-1:0] rdAddr = '0;
    logic          clrReq = 1'b0;
    logic [DW-1:0] rdDataA, rdDataB;
    logic          rdValidA, rdValidB, busyA, busyB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_ram_buffer #(.DATA_W(DW), .DEPTH(DEPTH_A), .READ_LAT(LAT_A), .CLEAR_ON_RESET(1)) dutA (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_valid(rdValidA),
        .clr_req(clrReq), .busy(busyA)
    );

    sdp_ram_buffer #(.DATA_W(DW), .DEPTH(DEPTH_B), .READ_LAT(LAT_B), .CLEAR_ON_RESET(1)) dutB (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
        .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_valid(rdValidB),
        .clr_req(clrReq), .busy(busyB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: memory image, remaining busy cycles and a queue of due read results.
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] refMem [2][1024];
    int          busyRemain [2];
    logic [31:0] expData [2];
    pend_t       pendA[$];
    pend_t       pendB[$];
    int          cyc = 0;
    bit          mAccA, mAccB;
    logic [31:0] mValA, mValB;

    function automatic int depthOf(input int d);
        return (d == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    task automatic modelStep(input int d, output bit rdAcc, output logic [31:0] val);
        int dep;
        dep   = depthOf(d);
        rdAcc = 1'b0;
        val   = '0;
        if (busyRemain[d] > 0) begin
            busyRemain[d]--;
        end else begin
            if (rdEn) begin
                rdAcc = 1'b1;
                if (int'(rdAddr) < dep) begin
                    val = refMem[d][rdAddr];
                    if (wrEn && wrAddr == rdAddr)
                        for (int b = 0; b < NB; b++)
                            if (wrBe[b]) val[8*b +: 8] = wrData[8*b +: 8];
                end
            end
            if (wrEn && int'(wrAddr) < dep)
                for (int b = 0; b < NB; b++)
                    if (wrBe[b]) refMem[d][wrAddr][8*b +: 8] = wrData[8*b +: 8];
            if (clrReq) begin
                for (int a = 0; a < 1024; a++) refMem[d][a] = '0;
                busyRemain[d] = dep;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int a = 0; a < 1024; a++) begin
                refMem[0][a] = '0;
                refMem[1][a] = '0;
            end
            busyRemain[0] = DEPTH_A;
            busyRemain[1] = DEPTH_B;
            expData[0]    = '0;
            expData[1]    = '0;
            pendA.delete();
            pendB.delete();
        end else begin
            modelStep(0, mAccA, mValA);
            modelStep(1, mAccB, mValB);
            if (mAccA) pendA.push_back('{cyc + LAT_A - 1, mValA});
            if (mAccB) pendB.push_back('{cyc + LAT_B - 1, mValB});
        end
        #1;
        if (pendA.size() > 0 && pendA[0].due == cyc) begin
            expData[0] = pendA[0].data;
            void'(pendA.pop_front());
            checkOutput("model A rd_valid", 32'(rdValidA), 32'd1);
        end else begin
            checkOutput("model A rd_valid", 32'(rdValidA), 32'd0);
        end
        if (pendB.size() > 0 && pendB[0].due == cyc) begin
            expData[1] = pendB[0].data;
            void'(pendB.pop_front());
            checkOutput("model B rd_valid", 32'(rdValidB), 32'd1);
        end else begin
            checkOutput("model B rd_valid", 32'(rdValidB), 32'd0);
        end
        checkOutput("model A rd_data", rdDataA, expData[0]);
        checkOutput("model B rd_data", rdDataB, expData[1]);
        checkOutput("model A busy", 32'(busyA), 32'(busyRemain[0] > 0));
        checkOutput("model B busy", 32'(busyB), 32'(busyRemain[1] > 0));
    end

    typedef struct {
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic [DW-1:0] wrData;
        logic [NB-1:0] wrBe;
        logic          rdEn;
        logic [AW-1:0] rdAddr;
        logic [DW-1:0] expA;
        logic [DW-1:0] expB;
    } vec_t;

    vec_t        vecs[$];
    vec_t        postClear[$];
    logic [31:0] seqVal [8];

    task automatic driveIdle();
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        clrReq = 1'b0;
        wrBe   = '0;
    endtask

    // One vector = one stimulus cycle; A answers after the first edge, B after the second.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        wrEn = v.wrEn; wrAddr = v.wrAddr; wrData = v.wrData; wrBe = v.wrBe;
        rdEn = v.rdEn; rdAddr = v.rdAddr;
        @(posedge clk); #1;
        if (v.rdEn) begin
            checkOutput({tag, " A rd_valid"}, 32'(rdValidA), 32'd1);
            checkOutput({tag, " A rd_data"}, rdDataA, v.expA);
            checkOutput({tag, " B early rd_valid"}, 32'(rdValidB), 32'd0);
        end
        @(negedge clk);
        driveIdle();
        @(posedge clk); #1;
        if (v.rdEn) begin
            checkOutput({tag, " B rd_valid"}, 32'(rdValidB), 32'd1);
            checkOutput({tag, " B rd_data"}, rdDataB, v.expB);
            checkOutput({tag, " A late rd_valid"}, 32'(rdValidA), 32'd0);
        end
    endtask

    task automatic countClear(input string tag);
        int cA = 0;
        int cB = 0;
        for (int i = 0; i < 1100; i++) begin
            cA += int'(busyA);
            cB += int'(busyB);
            @(posedge clk); #1;
        end
        checkOutput({tag, " A busy cycles"}, cA, DEPTH_A);
        checkOutput({tag, " B busy cycles"}, cB, DEPTH_B);
    endtask

    initial begin
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd1023, 32'h0,        32'h0});
        vecs.push_back('{1, 10'd5,    32'hDEADBEEF, 4'hF, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{1, 10'd5,    32'h11223344, 4'h5, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd5,    32'hDE22BE44, 32'hDE22BE44});
        vecs.push_back('{1, 10'd5,    32'hFFFFFFFF, 4'h0, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd5,    32'hDE22BE44, 32'hDE22BE44});
        vecs.push_back('{1, 10'd9,    32'hAAAAAAAA, 4'hF, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{1, 10'd9,    32'h12345678, 4'h3, 1, 10'd9,    32'hAAAA5678, 32'hAAAA5678});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd9,    32'hAAAA5678, 32'hAAAA5678});
        vecs.push_back('{1, 10'd999,  32'hCAFEF00D, 4'hF, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{1, 10'd1001, 32'h55555555, 4'hF, 0, 10'd0,    32'h0,        32'h0});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd1001, 32'h55555555, 32'h0});
        vecs.push_back('{0, 10'd0,    32'h0,        4'h0, 1, 10'd999,  32'hCAFEF00D, 32'hCAFEF00D});
        vecs.push_back('{1, 10'd1001, 32'h99999999, 4'hF, 1, 10'd1001, 32'h99999999, 32'h0});

        postClear.push_back('{0, 10'd0, 32'h0, 4'h0, 1, 10'd3,    32'h0, 32'h0});
        postClear.push_back('{0, 10'd0, 32'h0, 4'h0, 1, 10'd5,    32'h0, 32'h0});
        postClear.push_back('{0, 10'd0, 32'h0, 4'h0, 1, 10'd9,    32'h0, 32'h0});
        postClear.push_back('{0, 10'd0, 32'h0, 4'h0, 1, 10'd999,  32'h0, 32'h0});
        postClear.push_back('{0, 10'd0, 32'h0, 4'h0, 1, 10'd1001, 32'h0, 32'h0});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset A rd_data", rdDataA, 32'h0);
        checkOutput("reset B rd_data", rdDataB, 32'h0);
        checkOutput("reset A rd_valid", 32'(rdValidA), 32'd0);
        checkOutput("reset B busy", 32'(busyB), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        countClear("initial clear");

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back reads: results must arrive on consecutive cycles, in order.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seqVal[k] = $urandom;
            wrEn = 1'b1; wrAddr = AW'(k); wrData = seqVal[k]; wrBe = 4'hF;
        end
        @(negedge clk);
        driveIdle();
        repeat (3) @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            rdEn   = (k < 8);
            rdAddr = AW'(k % 8);
            @(posedge clk); #1;
            if (k == 0) begin
                checkOutput("burst B first rd_valid", 32'(rdValidB), 32'd0);
            end else begin
                checkOutput($sformatf("burst B rd_valid %0d", k - 1), 32'(rdValidB), 32'd1);
                checkOutput($sformatf("burst B rd_data %0d", k - 1), rdDataB, seqVal[k-1]);
            end
            if (k < 8) begin
                checkOutput($sformatf("burst A rd_data %0d", k), rdDataA, seqVal[k]);
            end else begin
                checkOutput("burst A trailing rd_valid", 32'(rdValidA), 32'd0);
            end
        end
        @(negedge clk);
        driveIdle();
        repeat (3) @(posedge clk);

        // Clear request followed by user traffic that must be ignored while busy.
        @(negedge clk);
        clrReq = 1'b1;
        @(negedge clk);
        clrReq = 1'b0;
        wrEn = 1'b1; wrAddr = 10'd3; wrData = 32'h77777777; wrBe = 4'hF;
        rdEn = 1'b1; rdAddr = 10'd3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checkOutput("busy-ignored A rd_valid", 32'(rdValidA), 32'd0);
            checkOutput("busy-ignored B rd_valid", 32'(rdValidB), 32'd0);
        end
        @(negedge clk);
        driveIdle();
        repeat (1100) @(posedge clk);
        for (int i = 0; i < postClear.size(); i++)
            applyStimulus(postClear[i], $sformatf("postclr%0d", i));

        // Reset in the middle of a clear must restart the full sequence.
        @(negedge clk);
        clrReq = 1'b1;
        @(negedge clk);
        clrReq = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        countClear("restarted clear");

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            wrEn   = 1'($urandom_range(0, 1));
            rdEn   = 1'($urandom_range(0, 1));
            wrAddr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
            rdAddr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
            wrData = $urandom;
            wrBe   = NB'($urandom);
        end
        @(negedge clk);
        driveIdle();
        repeat (5) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
